// File: rtl/spirose_pkg.sv
// rtl/spirose_pkg.sv - shared types and TLC5957 command framing constants
package spirose_pkg;

  typedef enum logic [2:0] {FC_EN, FC_WR, WAIT_SYNC, DELAY, STREAM} drv_state_t;

  localparam int TLC_WORD    = 48;
  localparam int WRTGS_LEN   = 1;
  localparam int LATGS_LEN   = 3;
  localparam int WRTFC_LEN   = 5;
  localparam int FCWRTEN_LEN = 15;

endpackage

// File: rtl/driver_controller_lat_gen.sv
// rtl/driver_controller_lat_gen.sv - asserts lat on the last len bits of a 48-bit word
module lat_gen
  import spirose_pkg::*;
(
  input  logic [5:0] bit_cnt,
  input  logic [4:0] len,
  output logic       lat
);

  assign lat = ({1'b0, bit_cnt} + {2'b00, len}) >= 7'(TLC_WORD);

endmodule

// File: rtl/driver_controller.sv
// rtl/driver_controller.sv - TLC5957 driver sequencer: FC write, then synced GS planes
module driver_controller
  import spirose_pkg::*;
#(
  parameter int          POKER_MODE     = 9,
  parameter int          LED_PER_DRIVER = 16,
  parameter int          MULTIPLEXING   = 8,
  parameter int          SYNC_DELAY     = 79,
  parameter logic [47:0] FC_DATA        = 48'h0
) (
  input  logic                    clk_33,
  input  logic                    nrst,
  input  logic [29:0]             data,
  input  logic                    sync,
  output logic                    drv_sclk_en,
  output logic [29:0]             drv_sin,
  output logic                    drv_lat,
  output logic                    drv_gclk_en,
  output logic [MULTIPLEXING-1:0] col_sel,
  output logic                    cfg_done
);

  localparam int PLANE_LEN = 3 * LED_PER_DRIVER;
  localparam int PW = $clog2(POKER_MODE);
  localparam int CW = $clog2(MULTIPLEXING);
  localparam int DW = $clog2(SYNC_DELAY + 1);

  drv_state_t    state;
  logic [5:0]    bit_cnt;
  logic [PW-1:0] plane_cnt;
  logic [CW-1:0] col_cnt;
  logic [DW-1:0] dly;
  logic          rotate;
  logic [4:0]    lat_len;
  logic          lat_next;
  logic          last_bit, last_plane, last_col;

  assign last_bit   = bit_cnt == 6'(PLANE_LEN - 1);
  assign last_plane = plane_cnt == PW'(POKER_MODE - 1);
  assign last_col   = col_cnt == CW'(MULTIPLEXING - 1);

  always_comb begin
    lat_len = 5'(WRTGS_LEN);
    if (state == FC_WR)   lat_len = 5'(WRTFC_LEN);
    else if (last_plane)  lat_len = 5'(LATGS_LEN);
  end

  lat_gen u_lat_gen (
    .bit_cnt (bit_cnt),
    .len     (lat_len),
    .lat     (lat_next)
  );

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      state       <= FC_EN;
      bit_cnt     <= '0;
      plane_cnt   <= '0;
      col_cnt     <= '0;
      dly         <= '0;
      rotate      <= 1'b0;
      drv_sclk_en <= 1'b0;
      drv_sin     <= '0;
      drv_lat     <= 1'b0;
      drv_gclk_en <= 1'b0;
      cfg_done    <= 1'b0;
      col_sel     <= {1'b1, {(MULTIPLEXING-1){1'b0}}};
    end else begin
      drv_sclk_en <= 1'b0;
      drv_sin     <= '0;
      drv_lat     <= 1'b0;
      rotate      <= 1'b0;
      // The column switches one cycle after the LATGS that loaded its data
      if (rotate) col_sel <= {col_sel[MULTIPLEXING-2:0], col_sel[MULTIPLEXING-1]};
      case (state)
        FC_EN: begin
          if (bit_cnt < 6'(FCWRTEN_LEN)) begin
            drv_sclk_en <= 1'b1;
            drv_lat     <= 1'b1;
            bit_cnt     <= bit_cnt + 6'd1;
          end else begin
            bit_cnt <= '0;
            state   <= FC_WR;
          end
        end
        FC_WR: begin
          drv_sclk_en <= 1'b1;
          drv_sin     <= {30{FC_DATA[6'(TLC_WORD-1) - bit_cnt]}};
          drv_lat     <= lat_next;
          if (last_bit) begin
            bit_cnt <= '0;
            state   <= WAIT_SYNC;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        WAIT_SYNC: begin
          cfg_done    <= 1'b1;
          drv_gclk_en <= 1'b1;
          if (sync) begin
            dly   <= DW'(SYNC_DELAY - 1);
            state <= DELAY;
          end
        end
        DELAY: begin
          if (sync)             dly   <= DW'(SYNC_DELAY - 1);
          else if (dly == '0)   state <= STREAM;
          else                  dly   <= dly - DW'(1);
        end
        STREAM: begin
          // A resync drops the word in flight; the final bit of a slice always completes
          if (sync && !(last_bit && last_plane && last_col)) begin
            bit_cnt   <= '0;
            plane_cnt <= '0;
            col_cnt   <= '0;
            dly       <= DW'(SYNC_DELAY - 1);
            state     <= DELAY;
          end else begin
            drv_sclk_en <= 1'b1;
            drv_sin     <= data;
            drv_lat     <= lat_next;
            if (!last_bit) begin
              bit_cnt <= bit_cnt + 6'd1;
            end else begin
              bit_cnt <= '0;
              if (!last_plane) begin
                plane_cnt <= plane_cnt + PW'(1);
              end else begin
                plane_cnt <= '0;
                rotate    <= 1'b1;
                if (!last_col) begin
                  col_cnt <= col_cnt + CW'(1);
                end else begin
                  col_cnt <= '0;
                  dly     <= DW'(SYNC_DELAY - 1);
                  state   <= sync ? DELAY : WAIT_SYNC;
                end
              end
            end
          end
        end
        default: state <= FC_EN;
      endcase
    end
  end

endmodule

// File: tb/tb_driver_controller.sv
// tb/tb_driver_controller.sv - randomized self-checking bench for driver_controller
module tb_driver_controller;

  localparam int          SLICE = 8 * 9 * 48;
  localparam logic [47:0] FC    = 48'hA5A5_0F0F_1234;

  logic        clk_33 = 1'b0;
  logic        nrst = 1'b0;
  logic [29:0] data = '0;
  logic        sync = 1'b0;
  logic        drv_sclk_en;
  logic [29:0] drv_sin;
  logic        drv_lat;
  logic        drv_gclk_en;
  logic [7:0]  col_sel;
  logic        cfg_done;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_col = 8'h80;
  logic [47:0] fc_word = FC;

  always #5 clk_33 = ~clk_33;

  driver_controller #(.FC_DATA(FC)) dut (
    .clk_33      (clk_33),
    .nrst        (nrst),
    .data        (data),
    .sync        (sync),
    .drv_sclk_en (drv_sclk_en),
    .drv_sin     (drv_sin),
    .drv_lat     (drv_lat),
    .drv_gclk_en (drv_gclk_en),
    .col_sel     (col_sel),
    .cfg_done    (cfg_done)
  );

  task automatic test_reset();
    nrst = 1'b0;
    sync = 1'b0;
    data = '0;
    repeat (2) @(negedge clk_33);
    checks++;
    if (drv_sclk_en !== 1'b0 || drv_lat !== 1'b0 || drv_sin !== 30'h0)
      begin failures++; $display("FAIL reset_outputs sclk=%b lat=%b sin=%h required 0 0 0", drv_sclk_en, drv_lat, drv_sin); end
    checks++;
    if (col_sel !== 8'h80)
      begin failures++; $display("FAIL reset_col_sel got=%h required=80", col_sel); end
    checks++;
    if (cfg_done !== 1'b0 || drv_gclk_en !== 1'b0)
      begin failures++; $display("FAIL reset_cfg cfg_done=%b gclk=%b required 0 0", cfg_done, drv_gclk_en); end
    exp_col = 8'h80;
  endtask

  // Random sync pulses are applied throughout configuration and must be ignored
  task automatic test_fc_config();
    logic        es, el;
    logic [29:0] ed;
    int          b;
    nrst = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk_33);
      es = 1'b0; el = 1'b0; ed = '0;
      if (k < 15) begin
        es = 1'b1; el = 1'b1;
      end else if (k >= 16 && k < 64) begin
        b  = k - 16;
        es = 1'b1;
        ed = {30{fc_word[47 - b]}};
        el = (b >= 43);
      end
      checks++;
      if (drv_sclk_en !== es || drv_lat !== el || drv_sin !== ed)
        begin failures++; $display("FAIL fc_seq k=%0d sclk=%b lat=%b sin=%h required %b %b %h", k, drv_sclk_en, drv_lat, drv_sin, es, el, ed); end
      checks++;
      if (cfg_done !== (k >= 64) || drv_gclk_en !== (k >= 64))
        begin failures++; $display("FAIL fc_done k=%0d cfg_done=%b gclk=%b required %b", k, cfg_done, drv_gclk_en, k >= 64); end
      sync = (k <= 62) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    repeat (4) begin
      @(negedge clk_33);
      checks++;
      if (drv_sclk_en !== 1'b0 || cfg_done !== 1'b1)
        begin failures++; $display("FAIL fc_idle sclk=%b cfg_done=%b required 0 1", drv_sclk_en, cfg_done); end
    end
  endtask

  // Issues a sync and checks every cycle of the slice against a plain arithmetic model.
  // abort_n: stream index at which a resync lands; chain: resync on the final bit.
  task automatic run_slice(input int abort_n, input bit chain, input bit walk);
    int          j, n, idx;
    bit          rot_due, restart;
    logic [29:0] live;
    logic        el;
    j = 0; idx = 0; rot_due = 1'b0;
    live = walk ? 30'd1 : 30'($urandom);
    data = live;
    sync = 1'b1;
    while (1) begin
      @(negedge clk_33);
      restart = 1'b0;
      if (rot_due) begin exp_col = {exp_col[6:0], exp_col[7]}; rot_due = 1'b0; end
      n = j - 80;
      if (abort_n >= 0 && n == abort_n) begin
        checks++;
        if (drv_sclk_en !== 1'b0 || drv_lat !== 1'b0 || col_sel !== exp_col)
          begin failures++; $display("FAIL resync_abort sclk=%b lat=%b col=%h required 0 0 %h", drv_sclk_en, drv_lat, col_sel, exp_col); end
        abort_n = -1;
        restart = 1'b1;
      end else if (j >= 80 && n < SLICE) begin
        el = (((n / 48) % 9) == 8) ? ((n % 48) >= 45) : ((n % 48) == 47);
        checks++;
        if (drv_sclk_en !== 1'b1 || drv_sin !== live)
          begin failures++; $display("FAIL stream_data n=%0d sclk=%b sin=%h required 1 %h", n, drv_sclk_en, drv_sin, live); end
        checks++;
        if (drv_lat !== el)
          begin failures++; $display("FAIL stream_lat n=%0d lat=%b required %b", n, drv_lat, el); end
        checks++;
        if (col_sel !== exp_col || drv_gclk_en !== 1'b1)
          begin failures++; $display("FAIL stream_col n=%0d col=%h gclk=%b required %h 1", n, col_sel, drv_gclk_en, exp_col); end
        if ((n % 432) == 431) rot_due = 1'b1;
        if (chain && n == SLICE - 1) begin chain = 1'b0; restart = 1'b1; end
      end else begin
        checks++;
        if (drv_sclk_en !== 1'b0 || drv_lat !== 1'b0 || drv_sin !== 30'h0 || col_sel !== exp_col)
          begin failures++; $display("FAIL idle j=%0d sclk=%b lat=%b sin=%h col=%h required 0 0 0 %h", j, drv_sclk_en, drv_lat, drv_sin, col_sel, exp_col); end
        if (n >= SLICE + 3) break;
      end
      j = restart ? 1 : j + 1;
      sync = ((abort_n >= 0 && (j - 80) == abort_n) || (chain && (j - 80) == SLICE - 1)) ? 1'b1 : 1'b0;
      idx++;
      live = walk ? (30'd1 << (idx % 30)) : 30'($urandom);
      data = live;
    end
    sync = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    sync = 1'b1;
    @(negedge clk_33);
    sync = 1'b0;
    repeat (600) begin
      @(negedge clk_33);
      data = 30'($urandom);
    end
    checks++;
    if (drv_sclk_en !== 1'b1)
      begin failures++; $display("FAIL pre_reset_stream sclk=%b required 1", drv_sclk_en); end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (drv_sclk_en !== 1'b0 || drv_lat !== 1'b0 || drv_sin !== 30'h0 || drv_gclk_en !== 1'b0 || cfg_done !== 1'b0)
      begin failures++; $display("FAIL async_reset sclk=%b lat=%b sin=%h gclk=%b cfg=%b required all 0", drv_sclk_en, drv_lat, drv_sin, drv_gclk_en, cfg_done); end
    checks++;
    if (col_sel !== 8'h80)
      begin failures++; $display("FAIL async_reset_col got=%h required=80", col_sel); end
    exp_col = 8'h80;
    @(negedge clk_33);
  endtask

  initial begin
    test_reset();
    test_fc_config();
    run_slice(-1, 1'b0, 1'b1);
    checks++;
    if (col_sel !== 8'h80)
      begin failures++; $display("FAIL slice_end_col got=%h required=80", col_sel); end
    run_slice(3 * 432 + 4 * 48 + 20, 1'b0, 1'b0);
    run_slice(-1, 1'b1, 1'b0);
    test_reset_mid_stream();
    test_fc_config();
    run_slice(-1, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
